// File: rtl/rr_mux_arbiter_if.sv
// Bus bundle for the two-source round-robin mux arbiter: two request/data
// sources on one side, a registered output word with valid/ready on the other.
interface rr_mux_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             req0;
   logic [WIDTH-1:0] d0;
   logic             gnt0;
   logic             req1;
   logic [WIDTH-1:0] d1;
   logic             gnt1;
   logic [WIDTH-1:0] q;
   logic             q_valid;
   logic             q_ready;
   logic             sel;
   logic             busy;

   // Producer/consumer side: drives requests, data and ready.
   modport master (
      output req0, d0, req1, d1, q_ready,
      input  gnt0, gnt1, q, q_valid, sel, busy
   );

   // Arbiter side.
   modport slave (
      input  req0, d0, req1, d1, q_ready,
      output gnt0, gnt1, q, q_valid, sel, busy
   );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin arbiter driving a registered 2:1 mux into a
// single-entry valid/ready output stage. A saturating burst counter bounds
// consecutive grants to one owner while the other source is waiting.
module rr_mux_arbiter #(
   parameter int WIDTH     = 8,
   parameter int BURST_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   rr_mux_arbiter_if.slave  bus
);

   localparam int             CW    = $clog2(BURST_MAX + 1);
   localparam logic [CW-1:0]  C_MAX = CW'(BURST_MAX);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SERVE0 = 2'd1;
   localparam logic [1:0] ST_SERVE1 = 2'd2;

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_last;
   logic [WIDTH-1:0] r_q;
   logic             r_q_valid;
   logic             r_sel;

   logic             w_slot_free;
   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_gnt_any;
   logic             w_own_req;
   logic             w_oth_req;
   logic [1:0]       w_other_st;
   logic [CW-1:0]    w_cnt_inc;
   logic [1:0]       w_state_nxt;
   logic [CW-1:0]    w_cnt_nxt;

   // A new word may enter the output stage if it is empty or being drained.
   assign w_slot_free = !r_q_valid || bus.q_ready;
   assign w_gnt0      = (r_state == ST_SERVE0) && bus.req0 && w_slot_free;
   assign w_gnt1      = (r_state == ST_SERVE1) && bus.req1 && w_slot_free;
   assign w_gnt_any   = w_gnt0 || w_gnt1;

   // Owner-relative view so both SERVE states share one transition rule.
   assign w_own_req   = (r_state == ST_SERVE1) ? bus.req1 : bus.req0;
   assign w_oth_req   = (r_state == ST_SERVE1) ? bus.req0 : bus.req1;
   assign w_other_st  = (r_state == ST_SERVE1) ? ST_SERVE0 : ST_SERVE1;
   assign w_cnt_inc   = (r_cnt >= C_MAX) ? C_MAX : r_cnt + 1'b1;

   // Next-state and burst-count decision.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a variable unassigned, which would otherwise infer a latch.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (bus.req0 && bus.req1) begin
               w_state_nxt = r_last ? ST_SERVE0 : ST_SERVE1;
            end else if (bus.req0) begin
               w_state_nxt = ST_SERVE0;
            end else if (bus.req1) begin
               w_state_nxt = ST_SERVE1;
            end
         end
         ST_SERVE0, ST_SERVE1: begin
            if (!w_own_req) begin
               w_state_nxt = w_oth_req ? w_other_st : ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (w_gnt_any) begin
               if ((w_cnt_inc == C_MAX) && w_oth_req) begin
                  w_state_nxt = w_other_st;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt   = w_cnt_inc;
               end
            end
            // Stall: owner still requesting but slot busy; hold everything.
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // FSM state, burst counter, round-robin memory and registered select.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_last  <= 1'b1;
         r_sel   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_sel   <= (w_state_nxt == ST_SERVE1);
         if (w_gnt0) begin
            r_last <= 1'b0;
         end else if (w_gnt1) begin
            r_last <= 1'b1;
         end
      end
   end

   // Output stage: capture the granted word, or drain when consumed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q       <= '0;
         r_q_valid <= 1'b0;
      end else begin
         if (w_gnt0) begin
            r_q       <= bus.d0;
            r_q_valid <= 1'b1;
         end else if (w_gnt1) begin
            r_q       <= bus.d1;
            r_q_valid <= 1'b1;
         end else if (r_q_valid && bus.q_ready) begin
            r_q_valid <= 1'b0;
         end
      end
   end

   assign bus.gnt0    = w_gnt0;
   assign bus.gnt1    = w_gnt1;
   assign bus.q       = r_q;
   assign bus.q_valid = r_q_valid;
   assign bus.sel     = r_sel;
   assign bus.busy    = (r_state != ST_IDLE);

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the shared registered 2:1 mux datapath (d0/d1 → sel → clocked q). It decides which source drives the mux and registers the winning word into a single-entry output stage with valid/ready backpressure. A burst limit bounds consecutive grants to one source while the other is waiting.

Parameters:
WIDTH, 8, data width of d0, d1 and q
BURST_MAX, 4, max consecutive grants to current owner while the other source requests (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req0  input  1  source 0 request; level, one transfer per granted cycle
d0  input  WIDTH  source 0 data; stable while req0 high and gnt0 low
gnt0  output  1  source 0 word accepted this cycle
req1  input  1  source 1 request
d1  input  WIDTH  source 1 data
gnt1  output  1  source 1 word accepted this cycle
q  output  WIDTH  registered output word
q_valid  output  1  q holds a valid word
q_ready  input  1  consumer accepts q this cycle when q_valid=1
sel  output  1  registered current owner (0 = d0, 1 = d1)
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, q=0, q_valid=0, sel=0, burst count=0, last_owner=1, so source 0 wins the first tie. gnt0=gnt1=0 and busy=0 while in reset.
- slot_free = !q_valid | q_ready.
- gntN = (state==SERVE_N) & reqN & slot_free. Combinational; never both high.
- On a grant: q <= dN and q_valid <= 1 at the next edge. Latency is one cycle from gnt to q_valid.
- If q_valid & q_ready and there is no grant: q_valid <= 0 and q holds its last value.
- FSM states: IDLE, SERVE0, SERVE1. sel = 1 in SERVE1, 0 otherwise (sel holds 0 in IDLE).
- IDLE transitions:
  - Only req0 → SERVE0.
  - Only req1 → SERVE1.
  - Both → the source != last_owner.
  - Neither → stay in IDLE.
  - Never grants from IDLE, so minimum req→q_valid is 2 cycles.
- SERVE_N transitions, evaluated in priority order:
  1. reqN=0 and other req=1 → SERVE_other, count=0.
  2. reqN=0 and other req=0 → IDLE, count=0.
  3. Grant this cycle: count' = min(count+1, BURST_MAX). If count'==BURST_MAX and other req=1 → SERVE_other, count=0. Otherwise stay.
  4. No grant (stall): stay; count unchanged; no switch during a stall.
- Switching between SERVE0 and SERVE1 is direct, with no IDLE bubble.
- last_owner updates to N on every grant from N.
- Count saturation: if the other source is idle, the owner continues past BURST_MAX with count saturated. When the other source then raises req, the switch occurs right after the owner's next grant.
- Simultaneous events:
  - Grant and drain in the same cycle: q is replaced and q_valid stays 1.
  - reqN falling in the same cycle as the last grant is legal.
- Stall: q and q_valid hold while q_valid=1 and q_ready=0. No gnt is issued.
- Reset mid-operation: the pending q word is discarded, q_valid clears immediately, and the FSM returns to IDLE. The first post-reset tie goes to source 0.
- Datapath: no arithmetic. The burst counter is clog2(BURST_MAX+1) bits, saturating, and never wraps.

Test Plan:
- Reset: rst=0 mid-stream with q_valid=1 → q=0, q_valid=0, sel=0, busy=0 immediately (before the next edge); after release, req0=req1=1 → source 0 served first.
- Single source: req0=1, d0=8'hA5, q_ready=1 → gnt0 in cycle 2, q=8'hA5 and q_valid=1 in cycle 3; the other source is never granted.
- Burst limit: req0=req1=1 held, q_ready=1, BURST_MAX=4 → sequence of 4 gnt0, 4 gnt1, 4 gnt0…; sel toggles with no idle cycle between owners.
- Backpressure: q_ready=0 for 5 cycles after the first grant → exactly one word captured, gnt low, q stable, count unchanged; resume → next grant in the same cycle q_ready rises.
- Owner drops request: source 1 owns with count=2; req1 falls and req0=1 → SERVE0 next cycle, gnt0 then, count restarts at 0.
- Late contender: source 0 streams 10 words alone (count saturates at 4), then req1 rises → exactly one more gnt0, then switch to gnt1.
